decode_stage: RTL and testbench

- ID stage of the 5-stage RV32I pipeline, directly downstream of fetch.
- Owns the IF/ID pipeline register, with stall, flush and valid handling.
- Decodes the registered instruction into control signals and a sign-extended immediate.
- Owns the 32x32 register file, with a writeback port and a same-cycle write-to-read bypass.
- Outputs feed the ID/EX register and the hazard unit.

---
 rtl/riscv_pkg.sv | 38 +++
 rtl/regfile.sv | 52 +++++
 rtl/decode_stage.sv | 193 +++++++++++++++++++
 tb/tb_decode_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode stage.
// Holds the opcode constants, the instruction placed in the IF/ID slot after
// reset or flush, and the enumerations for immediate format, ALU operation and
// writeback result source.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/regfile.sv
// 32 x XLEN integer register file: two combinational read ports, one
// synchronous write port, asynchronous active-low clear.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears all registers)
//   i_we, i_waddr,
//   i_wdata             write port (writes to x0 are discarded)
//   i_raddr1/2          read addresses
//   o_rdata1/2          read data, with same-cycle write bypass
module regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [32];
  logic            w_wr_en;
  logic [1:0][4:0]      w_raddr;
  logic [1:0][XLEN-1:0] w_rdata;

  assign w_wr_en = i_we && (i_waddr != 5'd0);

  // Entry 0 is never written, so it reads back as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign w_raddr = {i_raddr2, i_raddr1};

  // A write landing this cycle is forwarded so ID sees the value WB produces.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign w_rdata[gi] = (w_wr_en && (i_waddr == w_raddr[gi])) ? i_wdata
                                                               : r_regs[w_raddr[gi]];
  end

  assign o_rdata1 = w_rdata[0];
  assign o_rdata2 = w_rdata[1];

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: IF/ID pipeline register (stall/flush/valid), control decode,
// immediate generation and the register file with writeback bypass.
// Ports:
//   clk, rst                    clock, async active-low reset
//   InstrFD, PCF, PCPlus4FD     fetch-side instruction and PCs
//   StallD, FlushD              IF/ID hold / squash (flush has priority)
//   RegWriteW, RdW, ResultW     writeback port into the register file
//   RD1D, RD2D, ImmExtD         operands and sign-extended immediate
//   Rs1D, Rs2D, RdD             register indices
//   PCD, PCPlus4D               registered PCs
//   RegWriteD .. ALUControlD    control signals for EX/MEM/WB
//   ValidD, IllegalD            slot holds a real / an unsupported instruction
module decode_stage #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrFD,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4FD,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] RD1D,
  output logic [XLEN-1:0] RD2D,
  output logic [XLEN-1:0] ImmExtD,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            RegWriteD,
  output logic            MemWriteD,
  output logic            JumpD,
  output logic            BranchD,
  output logic            ALUSrcD,
  output logic [1:0]      ResultSrcD,
  output logic [2:0]      ALUControlD,
  output logic            ValidD,
  output logic            IllegalD
);

  import riscv_pkg::*;

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc4;
  logic            r_valid;

  // IF/ID register: flush beats stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (FlushD) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!StallD) begin
      r_instr <= InstrFD;
      r_pc    <= PCF;
      r_pc4   <= PCPlus4FD;
      r_valid <= 1'b1;
    end
  end

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_branch;
  logic        w_jump;
  logic        w_alu_src;
  logic        w_legal;
  logic        w_is_rtype;
  result_src_e w_result_src;
  imm_src_e    w_imm_src;
  alu_ctrl_e   w_alu_ctrl;
  alu_ctrl_e   w_alu_arith;

  assign w_opcode = r_instr[6:0];
  assign w_funct3 = r_instr[14:12];

  // ALU op for R-type and I-ALU; funct7[5] selects sub only for R-type since
  // the I-type form carries immediate bits there.
  always_comb begin
    w_alu_arith = ADD;
    case (w_funct3)
      3'b000:  w_alu_arith = ((w_opcode == OP_RTYPE) && r_instr[30]) ? SUB : ADD;
      3'b010:  w_alu_arith = SLT;
      3'b110:  w_alu_arith = OR;
      3'b111:  w_alu_arith = AND;
      default: w_alu_arith = ADD;
    endcase
  end

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_src    = 1'b0;
    w_result_src = RES_ALU;
    w_imm_src    = IMM_I;
    w_alu_ctrl   = ADD;
    w_legal      = 1'b1;
    w_is_rtype   = 1'b0;
    case (w_opcode)
      OP_LOAD: begin
        w_reg_write  = 1'b1;
        w_result_src = RES_MEM;
        w_alu_src    = 1'b1;
      end
      OP_STORE: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_src   = IMM_S;
      end
      OP_RTYPE: begin
        w_reg_write = 1'b1;
        w_is_rtype  = 1'b1;
        w_alu_ctrl  = w_alu_arith;
      end
      OP_ITYPE: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_alu_ctrl  = w_alu_arith;
      end
      OP_BRANCH: begin
        w_branch   = 1'b1;
        w_imm_src  = IMM_B;
        w_alu_ctrl = SUB;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_jump       = 1'b1;
        w_result_src = RES_PC4;
        w_imm_src    = IMM_J;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    ImmExtD = '0;
    if (!w_is_rtype) begin
      case (w_imm_src)
        IMM_I:   ImmExtD = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
        IMM_S:   ImmExtD = {{(XLEN-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
        IMM_B:   ImmExtD = {{(XLEN-12){r_instr[31]}}, r_instr[7], r_instr[30:25],
                            r_instr[11:8], 1'b0};
        IMM_J:   ImmExtD = {{(XLEN-20){r_instr[31]}}, r_instr[19:12], r_instr[20],
                            r_instr[30:21], 1'b0};
        default: ImmExtD = '0;
      endcase
    end
  end

  // Anything that changes architectural state is gated by the valid bit.
  assign RegWriteD   = r_valid & w_reg_write;
  assign MemWriteD   = r_valid & w_mem_write;
  assign BranchD     = r_valid & w_branch;
  assign JumpD       = r_valid & w_jump;
  assign IllegalD    = r_valid & ~w_legal;
  assign ALUSrcD     = w_alu_src;
  assign ResultSrcD  = w_result_src;
  assign ALUControlD = w_alu_ctrl;
  assign ValidD      = r_valid;
  assign PCD         = r_pc;
  assign PCPlus4D    = r_pc4;
  assign Rs1D        = r_instr[19:15];
  assign Rs2D        = r_instr[24:20];
  assign RdD         = r_instr[11:7];

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst_n    (rst),
    .i_we     (RegWriteW),
    .i_waddr  (RdW),
    .i_wdata  (ResultW),
    .i_raddr1 (Rs1D),
    .i_raddr2 (Rs2D),
    .o_rdata1 (RD1D),
    .o_rdata2 (RD2D)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver issues one fetch/writeback
// transaction per cycle and pushes the predicted ID outputs into a queue; a
// monitor on the falling edge pops and compares.
module tb_decode_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrFD, PCF, PCPlus4FD, ResultW;
  logic        StallD, FlushD, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD, IllegalD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .InstrFD(InstrFD), .PCF(PCF), .PCPlus4FD(PCPlus4FD),
    .StallD(StallD), .FlushD(FlushD), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .ValidD(ValidD), .IllegalD(IllegalD)
  );

  typedef struct {
    logic [31:0] instr, rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic [5:0]  ctl;      // {valid, illegal, regwrite, memwrite, branch, jump}
    logic        alusrc;
    logic [1:0]  ressrc;
    logic [2:0]  aluctl;
    bit          imm_care, alusrc_care, ressrc_care, alu_care;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // Reference state: what the ID slot and the architectural registers hold.
  logic [31:0] m_instr, m_pc, m_pc4;
  logic        m_valid;
  logic [31:0] m_regs [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_instr = NOP;
    m_pc    = '0;
    m_pc4   = '0;
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  function automatic logic [31:0] read_reg(input logic [4:0] idx);
    if (RegWriteW && RdW != 5'd0 && RdW == idx) return ResultW;
    return m_regs[idx];
  endfunction

  // Predicted outputs for the current ID contents and writeback inputs.
  function automatic exp_t predict();
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    int   imm;
    logic regw, memw, br, jmp, legal;
    op = m_instr[6:0];
    f3 = m_instr[14:12];
    e.instr = m_instr;
    e.rs1 = m_instr[19:15];
    e.rs2 = m_instr[24:20];
    e.rd  = m_instr[11:7];
    e.pc  = m_pc;
    e.pc4 = m_pc4;
    e.rd1 = read_reg(e.rs1);
    e.rd2 = read_reg(e.rs2);
    regw = 0; memw = 0; br = 0; jmp = 0; legal = 1;
    e.alusrc = 0; e.ressrc = 2'b00; e.aluctl = 3'b000;
    e.imm_care = 1; e.alusrc_care = 1; e.ressrc_care = 1; e.alu_care = 1;
    imm = 0;
    s12 = m_instr[31:20];
    if (op == 7'b0000011) begin            // lw
      regw = 1; e.ressrc = 2'b01; e.alusrc = 1; imm = s12;
    end else if (op == 7'b0100011) begin   // sw
      memw = 1; e.alusrc = 1; e.ressrc_care = 0;
      s12 = {m_instr[31:25], m_instr[11:7]}; imm = s12;
    end else if (op == 7'b0110011 || op == 7'b0010011) begin
      regw = 1;
      e.alusrc = (op == 7'b0010011);
      imm = (op == 7'b0010011) ? int'(s12) : 0;
      if (f3 == 3'b010)      e.aluctl = 3'b101;
      else if (f3 == 3'b110) e.aluctl = 3'b011;
      else if (f3 == 3'b111) e.aluctl = 3'b010;
      else if (f3 == 3'b000 && op == 7'b0110011 && m_instr[30]) e.aluctl = 3'b001;
      else e.aluctl = 3'b000;
    end else if (op == 7'b1100011) begin   // beq
      br = 1; e.aluctl = 3'b001; e.ressrc_care = 0;
      b13 = {m_instr[31], m_instr[7], m_instr[30:25], m_instr[11:8], 1'b0};
      imm = b13;
    end else if (op == 7'b1101111) begin   // jal
      regw = 1; jmp = 1; e.ressrc = 2'b10; e.alusrc_care = 0; e.alu_care = 0;
      j21 = {m_instr[31], m_instr[19:12], m_instr[20], m_instr[30:21], 1'b0};
      imm = j21;
    end else begin
      legal = 0;
      e.imm_care = 0; e.alusrc_care = 0; e.ressrc_care = 0; e.alu_care = 0;
    end
    e.imm = imm;
    e.ctl = {m_valid, m_valid & ~legal, m_valid & regw, m_valid & memw,
             m_valid & br, m_valid & jmp};
    return e;
  endfunction

  // One transaction: apply inputs, predict this cycle, then advance the model.
  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic stall, input logic flush,
                       input logic we, input logic [4:0] rd, input logic [31:0] res);
    InstrFD = instr; PCF = pc; PCPlus4FD = pc + 32'd4;
    StallD = stall; FlushD = flush;
    RegWriteW = we; RdW = rd; ResultW = res;
    q.push_back(predict());
    @(posedge clk);
    if (we && rd != 5'd0) m_regs[rd] = res;
    if (flush) begin
      m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = instr; m_pc = pc; m_pc4 = pc + 32'd4; m_valid = 1'b1;
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  ops [6];
    int k;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    w = $urandom;
    k = $urandom_range(0, 6);
    if (k < 6) begin
      w[6:0] = ops[k];
    end else begin
      for (int i = 0; i < 6; i++) if (w[6:0] == ops[i]) w[6:0] = 7'h7F;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_txn++;
      $display("txn %0d: instr=%h pc=%h valid=%0d rd1=%h rd2=%h imm=%h",
               n_txn, mon_e.instr, mon_e.pc, mon_e.ctl[5], mon_e.rd1, mon_e.rd2, mon_e.imm);
      check("operands", {RD1D, RD2D}, {mon_e.rd1, mon_e.rd2});
      check("indices", {Rs1D, Rs2D, RdD}, {mon_e.rs1, mon_e.rs2, mon_e.rd});
      check("pcs", {PCD, PCPlus4D}, {mon_e.pc, mon_e.pc4});
      check("valid_illegal_ctl", {ValidD, IllegalD, RegWriteD, MemWriteD, BranchD, JumpD},
            mon_e.ctl);
      if (mon_e.imm_care)    check("immext", ImmExtD, mon_e.imm);
      if (mon_e.alusrc_care) check("alusrc", ALUSrcD, mon_e.alusrc);
      if (mon_e.ressrc_care) check("resultsrc", ResultSrcD, mon_e.ressrc);
      if (mon_e.alu_care)    check("aluctl", ALUControlD, mon_e.aluctl);
    end
  end

  initial begin
    rst = 1'b0;
    InstrFD = 32'h00500093; PCF = '0; PCPlus4FD = '0;
    StallD = 0; FlushD = 0; RegWriteW = 0; RdW = '0; ResultW = '0;
    model_reset();
    #1;
    check("reset_valid", ValidD, 1'b0);
    check("reset_pc", {PCD, PCPlus4D}, 64'd0);
    check("reset_ctl", {RegWriteD, MemWriteD, BranchD, JumpD, IllegalD}, 5'd0);
    check("reset_nop_fields", {RdD, Rs1D, ImmExtD}, 42'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // addi x1,x0,5 enters; first cycle still shows the reset NOP
    drive(32'h00500093, 32'h100, 0, 0, 0, 5'd0, 32'h0);
    // sw x2,-4(x1) enters; ID shows addi
    drive(32'hFE20AE23, 32'h104, 0, 0, 0, 5'd0, 32'h0);
    // ID holds sw (rs1=1): writeback to x1 is bypassed, stall keeps sw
    drive(32'h00208463, 32'h108, 1, 0, 1, 5'd1, 32'hDEADBEEF);
    // sw still in ID, x1 now read from the file; beq enters
    drive(32'h00208463, 32'h108, 0, 0, 0, 5'd0, 32'h0);
    // beq in ID; addi (rs1=x0) enters
    drive(32'h00500093, 32'h10C, 0, 0, 0, 5'd0, 32'h0);
    // addi in ID with a write to x0 in flight: RD1 must stay 0
    drive(32'h80208463, 32'h110, 0, 0, 1, 5'd0, 32'h12345678);
    // negative-offset beq in ID
    drive(32'h40208033, 32'h114, 0, 0, 0, 5'd0, 32'h0);
    // hold for three cycles while fetch keeps changing
    for (int i = 0; i < 3; i++) drive(rand_instr(), 32'h200 + 4 * i, 1, 0, 0, 5'd0, 32'h0);
    // stall and flush together: flush wins
    drive(32'h00A00113, 32'h300, 1, 1, 0, 5'd0, 32'h0);
    // illegal opcode enters after the bubble
    drive(32'h0000007F, 32'h304, 0, 0, 0, 5'd0, 32'h0);
    drive(32'h00000033, 32'h308, 1, 0, 0, 5'd0, 32'h0);

    // Illegal instruction now in ID: predict it, then reset mid-cycle.
    q.push_back(predict());
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_illegal", IllegalD, 1'b0);
    check("async_valid", ValidD, 1'b0);
    check("async_pc", PCD, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;

    // Random traffic; register contents after the mid-run reset start at zero.
    for (int n = 0; n < 300; n++) begin
      drive(rand_instr(), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
    end
    StallD = 1; RegWriteW = 0;
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
